instr_dispatch: RTL and testbench
=================================

Name: instr_dispatch

Overview:
- Top-level instruction sequencer for the simple CPU.
- Fetches 16-bit instruction words (opCode[15:12], Ri[11:6], Rj[5:0]) from a synchronous instruction memory and decodes the opcode.
- Starts exactly one execution sub-FSM (ALU, MOV, LOAD, STORE), holds the decoded fields stable, waits for that unit's done, then advances the PC.
- Owns halt, illegal-opcode and watchdog-timeout handling.

Parameters:
- ADDR_W, 8, width of PC / instruction address.
- TIMEOUT, 15, max cycles in WAIT for done before error; must be >= 1.

Ports:
- clk input 1 system clock
- reset input 1 async active-high reset
- run input 1 level; enables fetching of new instructions
- restart input 1 pulse; leaves HALTED/ERROR, PC := 0
- instr_addr output ADDR_W instruction memory address (= PC)
- instr_rd output 1 memory read strobe; data valid one cycle later
- instr_data input 16 instruction word
- opCode output 4 decoded opcode to sub-FSMs
- Ri output 6 decoded Ri to sub-FSMs
- Rj output 6 decoded Rj to sub-FSMs
- unit_start output 4 one-hot start; bit0 ALU, bit1 MOV, bit2 LOAD, bit3 STORE
- unit_done input 4 done from each sub-FSM
- busy output 1 high in any state other than IDLE, HALTED, ERROR
- halted output 1 high in HALTED
- error output 1 high in ERROR
- err_code output 2 01 illegal opcode, 10 timeout, 00 none

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high. Reset drives every output to 0, PC = 0, state = IDLE, instruction register = 0, timeout counter = 0.
- Outputs are registered except busy, halted and error, which are decoded from state.
- States and transitions:
  - IDLE: go to FETCH when run = 1.
  - FETCH: instr_rd = 1 for exactly one cycle; go to LATCH.
  - LATCH: capture instr_data into the instruction register; go to DECODE.
  - DECODE: drive opCode, Ri and Rj from the register; classify the opcode.
- Opcode classification in DECODE:
  - 0000 NOP: go to NEXT.
  - 0001 MOV (unit1), 0010 LOAD (unit2), 0011 STORE (unit3), 0100-0111 ALU (unit0): go to ISSUE.
  - 1111 HALT: go to HALTED.
  - All other opcodes: go to ERROR with err_code = 01.
- ISSUE: the selected unit_start bit is high for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Sample only the selected unit's done bit. When it is 1, go to NEXT.
  - Each cycle without done increments the counter. When the counter reaches TIMEOUT, go to ERROR with err_code = 10.
  - Done bits of non-selected units are ignored in every state.
- NEXT:
  - PC := PC + 1, wrapping 2^ADDR_W-1 -> 0.
  - If run = 1, go to FETCH; otherwise go to IDLE.
- HALTED and ERROR:
  - Hold PC, opCode, Ri and Rj; unit_start = 0.
  - restart = 1: PC := 0, err_code := 00, go to IDLE.
  - run is ignored in these states.
- opCode, Ri and Rj are stable from DECODE through NEXT. They change only in LATCH/DECODE of the next instruction.
- run deasserted mid-instruction: the current instruction completes normally, then the block returns to IDLE at NEXT.
- restart outside HALTED/ERROR is ignored.
- Reset mid-operation aborts immediately; no start pulse is issued after reset.
- Latency for an ALU instruction whose done arrives d cycles after the start pulse: FETCH to FETCH = 5 + d cycles.
- A NOP costs 4 cycles (FETCH, LATCH, DECODE, NEXT).

Optional Feature:
- Macro: INSTR_DISPATCH_SINGLE_STEP_EN.
- When defined:
  - Add input step (1 bit) and state STEP_WAIT.
  - NEXT goes to STEP_WAIT instead of FETCH.
  - STEP_WAIT goes to FETCH on step = 1, or to IDLE if run = 0.
  - busy is low in STEP_WAIT.
- When not defined: the step port and STEP_WAIT do not exist, and NEXT behaves as described above.

Test Plan:
- Memory[0] = 0x7042 (ALU, Ri=1, Rj=2), run = 1, unit_done[0] pulses 5 cycles after start:
  - opCode = 7, Ri = 1, Rj = 2 are stable throughout.
  - unit_start = 0001 for 1 cycle.
  - PC = 1 and FETCH recurs 10 cycles after the first FETCH.
- Memory = {0x1000, 0x0000, 0xF000}:
  - unit_start = 0010 once; the NOP issues no start.
  - halted = 1 with PC = 2.
  - restart -> PC = 0, IDLE.
- Memory[0] = 0x9000 -> error = 1, err_code = 01, unit_start never asserted.
- Memory[0] = 0x2000 with unit_done never asserted -> ERROR with err_code = 10 exactly TIMEOUT cycles after entering WAIT.
- ALU instruction, with unit_done[1] asserted during WAIT and unit_done[0] held low -> remains in WAIT until unit_done[0] is asserted.
- Reset asserted during WAIT -> all outputs 0 and PC = 0 asynchronously.
- PC = 255 (ADDR_W = 8) after a NOP -> wraps to 0.

Source files
------------

// File: rtl/instr_dispatch.sv
// instr_dispatch: fetch/decode/issue sequencer that starts one execution unit per instruction.
// Optional single-step mode is enabled by defining INSTR_DISPATCH_SINGLE_STEP_EN.
module instr_dispatch #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_rd,
  input  logic [15:0]       instr_data,
  output logic [3:0]        opCode,
  output logic [5:0]        Ri,
  output logic [5:0]        Rj,
  output logic [3:0]        unit_start,
  input  logic [3:0]        unit_done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_HALTED,
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
    S_STEP_WAIT,
`endif
    S_ERROR
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [15:0]        r_ir;
  logic [3:0]         r_sel;
  logic [3:0]         r_start;
  logic               r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_err;

  logic [3:0]         w_op;
  logic [3:0]         w_sel;
  logic               w_done;

  assign w_op = r_ir[15:12];

  // One-hot unit select: opcodes 1..3 map to MOV/LOAD/STORE, 4..7 to the ALU.
  always_comb begin
    w_sel = 4'b0000;
    case (w_op)
      4'h1:                   w_sel = 4'b0010;
      4'h2:                   w_sel = 4'b0100;
      4'h3:                   w_sel = 4'b1000;
      4'h4, 4'h5, 4'h6, 4'h7: w_sel = 4'b0001;
      default:                w_sel = 4'b0000;
    endcase
  end

  assign w_done = |(unit_done & r_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_sel   <= '0;
      r_start <= '0;
      r_rd    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 2'b00;
    end else begin
      r_rd    <= 1'b0;
      r_start <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
          end
        end
        S_FETCH:  r_state <= S_LATCH;
        S_LATCH: begin
          r_ir    <= instr_data;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_op)
            4'h0: r_state <= S_NEXT;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              r_sel   <= w_sel;
              r_start <= w_sel;
              r_state <= S_ISSUE;
            end
            4'hF: r_state <= S_HALTED;
            default: begin
              r_err   <= 2'b01;
              r_state <= S_ERROR;
            end
          endcase
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        // Timeout fires on the TIMEOUT-th consecutive cycle without done.
        S_WAIT: begin
          if (w_done) begin
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_err   <= 2'b10;
              r_state <= S_ERROR;
            end
          end
        end
        S_NEXT: begin
          r_pc <= r_pc + ADDR_W'(1);
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
          r_state <= S_STEP_WAIT;
`else
          if (run) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
`endif
        end
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
        S_STEP_WAIT: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (step) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
          end
        end
`endif
        S_HALTED, S_ERROR: begin
          if (restart) begin
            r_pc    <= '0;
            r_err   <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_addr = r_pc;
  assign instr_rd   = r_rd;
  assign opCode     = r_ir[15:12];
  assign Ri         = r_ir[11:6];
  assign Rj         = r_ir[5:0];
  assign unit_start = r_start;
  assign err_code   = r_err;
  assign halted     = (r_state == S_HALTED);
  assign error      = (r_state == S_ERROR);
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
  assign busy = !((r_state == S_IDLE) || (r_state == S_HALTED) ||
                  (r_state == S_ERROR) || (r_state == S_STEP_WAIT));
`else
  assign busy = !((r_state == S_IDLE) || (r_state == S_HALTED) || (r_state == S_ERROR));
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed and random programs checked against a per-instruction latency model.
module tb_instr_dispatch;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              rs_cmd = 1'b0;
  logic              rs_nz  = 1'b0;
  logic              restart;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_rd;
  logic [15:0]       instr_data;
  logic [3:0]        opCode;
  logic [5:0]        Ri, Rj;
  logic [3:0]        unit_start;
  logic [3:0]        unit_done = 4'b0000;
  logic              busy, halted, error;
  logic [1:0]        err_code;
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
  logic              step = 1'b1;
`endif

  assign restart = rs_cmd | rs_nz;

  instr_dispatch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .restart(restart),
`ifdef INSTR_DISPATCH_SINGLE_STEP_EN
    .step(step),
`endif
    .instr_addr(instr_addr), .instr_rd(instr_rd), .instr_data(instr_data),
    .opCode(opCode), .Ri(Ri), .Rj(Rj), .unit_start(unit_start), .unit_done(unit_done),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:255];
  int dly [0:255];
  int cyc = 0;
  bit rs_noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (instr_rd) instr_data <= mem[instr_addr];

  // Execution units: the selected unit answers dly cycles after its start; other done bits are noise.
  logic [3:0] cur_sel = 4'b0000;
  int cnt = -1;
  always @(negedge clk) begin
    logic [3:0] d;
    if (reset) begin
      cur_sel = 4'b0000;
      cnt = -1;
      unit_done = 4'b0000;
      rs_nz = 1'b0;
    end else begin
      if (unit_start != 4'b0000) begin
        cur_sel = unit_start;
        cnt = dly[instr_addr];
      end else if (cnt > 0) begin
        cnt = cnt - 1;
      end
      d = 4'($urandom) & ~cur_sel;
      if (cnt == 0) begin
        d = d | cur_sel;
        cnt = -1;
      end
      unit_done = d;
      rs_nz = (rs_noise && !halted && !error) ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  end

  bit mon_en = 1'b0;
  int end_t = -1;
  int obs_ft[$], obs_fpc[$], obs_st[$];
  logic [3:0]  obs_sv[$];
  logic [15:0] obs_sw[$];
  logic        obs_sb[$];
  always @(negedge clk) begin
    if (!mon_en) begin
      obs_ft.delete(); obs_fpc.delete(); obs_st.delete();
      obs_sv.delete(); obs_sw.delete(); obs_sb.delete();
      end_t = -1;
    end else begin
      if (instr_rd) begin
        obs_ft.push_back(cyc);
        obs_fpc.push_back(int'(instr_addr));
      end
      if (unit_start != 4'b0000) begin
        obs_st.push_back(cyc);
        obs_sv.push_back(unit_start);
        obs_sw.push_back({opCode, Ri, Rj});
        obs_sb.push_back(busy);
      end
      if ((halted || error) && end_t < 0) end_t = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    rs_cmd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hF000;
      dly[i] = 1;
    end
  endtask

  // Reference: walk the program with the instruction-level latencies (NOP 4, unit 5+d, halt/illegal +3, timeout 4+TIMEOUT).
  task automatic run_prog(input string name);
    int exp_ft[$], exp_fpc[$], exp_st[$];
    logic [3:0] exp_sv[$];
    logic [15:0] exp_sw[$];
    int pc, t, op, exp_end, n, base, lim;
    bit exp_err;
    logic [1:0] exp_code;
    pc = 0; t = 0; exp_end = -1; exp_err = 1'b0; exp_code = 2'b00;
    for (int i = 0; i < 400 && exp_end < 0; i++) begin
      exp_ft.push_back(t);
      exp_fpc.push_back(pc);
      op = int'(mem[pc][15:12]);
      if (op == 0) begin
        t += 4;
        pc = (pc + 1) % 256;
      end else if (op <= 7) begin
        exp_st.push_back(t + 3);
        exp_sv.push_back(op >= 4 ? 4'b0001 : 4'(1 << op));
        exp_sw.push_back(mem[pc]);
        if (dly[pc] < 0) begin
          exp_end = t + 4 + TIMEOUT; exp_err = 1'b1; exp_code = 2'b10;
        end else begin
          t += 5 + dly[pc];
          pc = (pc + 1) % 256;
        end
      end else if (op == 15) begin
        exp_end = t + 3; exp_err = 1'b0; exp_code = 2'b00;
      end else begin
        exp_end = t + 3; exp_err = 1'b1; exp_code = 2'b01;
      end
    end

    do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    rs_noise = 1'b1;
    run = 1'b1;
    n = 0;
    while (!(halted || error) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rs_noise = 1'b0;

    base = (obs_ft.size() > 0) ? obs_ft[0] : 0;
    chk({name, " fetch_count"}, obs_ft.size(), exp_ft.size());
    lim = (obs_ft.size() < exp_ft.size()) ? obs_ft.size() : exp_ft.size();
    for (int k = 0; k < lim; k++) begin
      chk($sformatf("%s fetch%0d_time", name, k), obs_ft[k] - base, exp_ft[k]);
      chk($sformatf("%s fetch%0d_pc", name, k), obs_fpc[k], exp_fpc[k]);
    end
    chk({name, " start_count"}, obs_st.size(), exp_st.size());
    lim = (obs_st.size() < exp_st.size()) ? obs_st.size() : exp_st.size();
    for (int k = 0; k < lim; k++) begin
      chk($sformatf("%s start%0d_time", name, k), obs_st[k] - base, exp_st[k]);
      chk($sformatf("%s start%0d_vec", name, k), 32'(obs_sv[k]), 32'(exp_sv[k]));
      chk($sformatf("%s start%0d_fields", name, k), 32'(obs_sw[k]), 32'(exp_sw[k]));
      chk($sformatf("%s start%0d_busy", name, k), 32'(obs_sb[k]), 32'd1);
    end
    chk({name, " end_time"}, end_t - base, exp_end);
    chk({name, " halted"}, 32'(halted), 32'(!exp_err));
    chk({name, " error"}, 32'(error), 32'(exp_err));
    chk({name, " err_code"}, 32'(err_code), 32'(exp_code));
    chk({name, " end_pc"}, 32'(instr_addr), pc);
    chk({name, " end_busy"}, 32'(busy), 32'd0);

    run = 1'b0;
    @(negedge clk);
    rs_cmd = 1'b1;
    @(negedge clk);
    rs_cmd = 1'b0;
    @(negedge clk);
    chk({name, " restart_pc"}, 32'(instr_addr), 32'd0);
    chk({name, " restart_state"}, {29'd0, busy, halted, error}, 32'd0);
    chk({name, " restart_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, len, kind;
    bit quiet;
    reset = 1'b1;
    run = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {instr_addr, instr_rd, opCode, Ri, Rj, unit_start, busy, halted, error, err_code},
        32'd0);

    // ALU with delay 5: fetch-to-fetch 10 cycles.
    clear_mem();
    mem[0] = 16'h7042; dly[0] = 5;
    run_prog("alu");
    chk("alu fetch_interval", (obs_ft.size() > 1) ? obs_ft[1] - obs_ft[0] : -1, 10);
    chk("alu second_pc", (obs_fpc.size() > 1) ? obs_fpc[1] : -1, 1);

    clear_mem();
    mem[0] = 16'h1000; mem[1] = 16'h0000; mem[2] = 16'hF000; dly[0] = 3;
    run_prog("mov_nop_halt");

    clear_mem();
    mem[0] = 16'h9000;
    run_prog("illegal");

    clear_mem();
    mem[0] = 16'h2000; dly[0] = -1;
    run_prog("timeout");

    for (int r = 0; r < 6; r++) begin
      clear_mem();
      len = $urandom_range(2, 8);
      for (int i = 0; i < len; i++) begin
        mem[i] = {4'($urandom_range(0, 7)), 12'($urandom)};
        dly[i] = $urandom_range(1, 6);
      end
      kind = $urandom_range(0, 2);
      if (kind == 0) mem[len] = {4'hF, 12'($urandom)};
      else if (kind == 1) mem[len] = {4'($urandom_range(8, 14)), 12'($urandom)};
      else begin
        mem[len] = {4'($urandom_range(1, 7)), 12'($urandom)};
        dly[len] = -1;
      end
      run_prog($sformatf("rand%0d", r));
    end

    // PC wrap: 256 NOPs, run dropped during the last one.
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run = 1'b1;
    n = 0;
    while (!(instr_rd && instr_addr == 8'd255) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
    chk("wrap fetch_count", obs_ft.size(), 256);
    chk("wrap last_fetch_pc", (obs_fpc.size() > 0) ? obs_fpc[obs_fpc.size() - 1] : -1, 255);
    chk("wrap pc", 32'(instr_addr), 32'd0);
    chk("wrap idle", {30'd0, busy, instr_rd}, 32'd0);

    // Asynchronous reset while waiting on the ALU.
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h4555; dly[1] = -1;
    do_reset();
    run = 1'b1;
    n = 0;
    while (unit_start == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("wait busy_before_reset", {31'd0, busy}, 32'd1);
    chk("wait pc_before_reset", 32'(instr_addr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {instr_addr, instr_rd, opCode, Ri, Rj, unit_start, busy, halted, error, err_code}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (unit_start != 4'b0000 || busy) quiet = 1'b0;
    end
    chk("post_reset_quiet", {31'd0, quiet}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
